// File: rtl/btb_update_writer.sv
// ---------------------------------------------------------------------------
// btb_update_writer
//
// Write side of the 2-way x 8-set branch target buffer. Resolved branch
// updates from EX are buffered in a small FIFO and processed one at a time:
//   LOOKUP : read the set, pick the hit way (way 0 wins a double hit) or the
//            LRU victim, apply the 2-bit saturating counter rule.
//   WRITE  : hold one array write until the write port is granted; the grant
//            cycle also pulses the LRU update for that set.
// A not-taken update that misses allocates nothing and is simply dropped.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             drop all buffered and ungranted updates
//   ex_valid/ex_ready update handshake from EX (ready = FIFO not full)
//   ex_pc/ex_target/ex_taken   resolved branch fields
//   rd_set            set index driven to the tag arrays during LOOKUP
//   rd_valid/rd_tag*/rd_ctr*   same-cycle array read data for rd_set
//   lru_in            per-set victim way
//   wr_en/wr_grant    array write request / grant
//   wr_way/wr_set/wr_tag/wr_target/wr_ctr   write fields (valid implied 1)
//   lru_upd_write/lru_upd_index   one-cycle LRU update pulse and its set
// ---------------------------------------------------------------------------
module btb_update_writer #(
    parameter int TAG_W      = 27,
    parameter int SET_W      = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [31:0]           ex_pc,
    input  logic [31:0]           ex_target,
    input  logic                  ex_taken,
    output logic [SET_W-1:0]      rd_set,
    input  logic [1:0]            rd_valid,
    input  logic [TAG_W-1:0]      rd_tag0,
    input  logic [TAG_W-1:0]      rd_tag1,
    input  logic [1:0]            rd_ctr0,
    input  logic [1:0]            rd_ctr1,
    input  logic [(1<<SET_W)-1:0] lru_in,
    output logic                  wr_en,
    input  logic                  wr_grant,
    output logic                  wr_way,
    output logic [SET_W-1:0]      wr_set,
    output logic [TAG_W-1:0]      wr_tag,
    output logic [31:0]           wr_target,
    output logic [1:0]            wr_ctr,
    output logic                  lru_upd_write,
    output logic [SET_W-1:0]      lru_upd_index
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [SET_W-1:0] set;
        logic [31:0]      target;
        logic             taken;
    } upd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Update FIFO
    // ------------------------------------------------------------------
    upd_t             fifo_mem [FIFO_DEPTH];
    upd_t             push_entry;
    upd_t             head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             full, push, pop;

    // PC[1:0] carries no information for the BTB.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, ex_pc[1:0]};

    assign push_entry = {ex_pc[31 -: TAG_W], ex_pc[SET_W+1:2], ex_target, ex_taken};
    assign head       = fifo_mem[rd_ptr];

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign ex_ready = !full;
    assign push     = ex_valid && !full && !flush;
    // Every LOOKUP consumes its entry, whether or not it leads to a write.
    assign pop      = (state == LOOKUP) && !flush;
    // Occupancy after this edge; the FSM uses it so a push in the same cycle
    // is seen immediately (accept at N -> LOOKUP at N+1).
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_entry;
    end

    // ------------------------------------------------------------------
    // Lookup: way selection and counter rule
    // ------------------------------------------------------------------
    logic       hit0, hit1, hit, hit_way;
    logic [1:0] old_ctr, new_ctr;
    logic       lk_way;
    logic [1:0] lk_ctr;

    assign hit0    = rd_valid[0] && (rd_tag0 == head.tag);
    assign hit1    = rd_valid[1] && (rd_tag1 == head.tag);
    assign hit     = hit0 || hit1;
    assign hit_way = !hit0;                 // way 0 wins a double hit
    assign old_ctr = hit0 ? rd_ctr0 : rd_ctr1;

    always_comb begin
        new_ctr = old_ctr;
        if (head.taken) begin
            if (old_ctr != 2'b11) new_ctr = old_ctr + 2'd1;
        end else begin
            if (old_ctr != 2'b00) new_ctr = old_ctr - 2'd1;
        end
    end

    // A taken miss allocates into the victim way, weakly taken.
    assign lk_way = hit ? hit_way : lru_in[head.set];
    assign lk_ctr = hit ? new_ctr : 2'b10;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (count_nxt != '0) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (!hit && !head.taken) begin
                    state_nxt = (count_nxt != '0) ? LOOKUP : IDLE;
                end else begin
                    load      = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (wr_grant) state_nxt = (count_nxt != '0) ? LOOKUP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A coincident grant still completes (its pulse is combinational);
        // anything else in flight is dropped.
        if (flush) begin
            state_nxt = IDLE;
            load      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Write-field registers: captured in LOOKUP, held through WRITE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_way    <= 1'b0;
            wr_set    <= '0;
            wr_tag    <= '0;
            wr_target <= '0;
            wr_ctr    <= '0;
        end else if (load) begin
            wr_way    <= lk_way;
            wr_set    <= head.set;
            wr_tag    <= head.tag;
            wr_target <= head.target;
            wr_ctr    <= lk_ctr;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded from state so reset drops them at once)
    // ------------------------------------------------------------------
    assign wr_en         = (state == WRITE);
    assign lru_upd_write = wr_en && wr_grant;
    assign lru_upd_index = lru_upd_write ? wr_set : '0;
    assign rd_set        = (state == LOOKUP) ? head.set : '0;

endmodule
